mem_arbiter: RTL and testbench

Two-port arbiter that shares one `mem_interface` instance between two requesters: port 0 (instruction fetch) and port 1 (data load/store). It sits between the core pipeline stages and the memory interface. It serialises accesses with a small state machine and grants fairly by round-robin. Each access returns a one-cycle completion pulse to the requester that owns it.

---
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that serialises fetch (port 0) and load/store (port 1)
// accesses onto a single memory interface, one access in flight at a time.
module mem_arbiter #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0_read,
    input  logic                    req0_write,
    input  logic [ADDRESS_BITS-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0]   req0_in_data,
    output logic                    req0_ready,
    output logic                    req0_valid,
    output logic [DATA_WIDTH-1:0]   req0_out_data,
    input  logic                    req1_read,
    input  logic                    req1_write,
    input  logic [ADDRESS_BITS-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0]   req1_in_data,
    output logic                    req1_ready,
    output logic                    req1_valid,
    output logic [DATA_WIDTH-1:0]   req1_out_data,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_in_data,
    input  logic [DATA_WIDTH-1:0]   mem_out_data,
    input  logic                    report
);
    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam logic [LW-1:0] LAST = LW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state;
    logic                    grant, last_grant, op_write;
    logic [LW-1:0]           lat_cnt;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    want0, want1, pick, take, in_access, unused_report;

    always_comb begin
        want0         = req0_read | req0_write;
        want1         = req1_read | req1_write;
        pick          = (want0 & want1) ? ~last_grant : want1;
        take          = ~reset & (state == IDLE) & (want0 | want1);
        in_access     = state == ACCESS;
        req0_ready    = take & ~pick;
        req1_ready    = take & pick;
        req0_valid    = (state == DONE) & ~grant;
        req1_valid    = (state == DONE) & grant;
        mem_read      = in_access & ~op_write;
        mem_write     = in_access & op_write;
        mem_address   = in_access ? addr_q : '0;
        mem_in_data   = (in_access & op_write) ? data_q : '0;
        unused_report = report ^ CORE[0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            op_write      <= 1'b0;
            lat_cnt       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            req0_out_data <= '0;
            req1_out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (want0 | want1) begin
                        grant      <= pick;
                        last_grant <= pick;
                        op_write   <= pick ? req1_write : req0_write;
                        addr_q     <= pick ? req1_address : req0_address;
                        data_q     <= pick ? req1_in_data : req0_in_data;
                        lat_cnt    <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (op_write) begin
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                        if (lat_cnt == LAST) begin
                            if (grant) req1_out_data <= mem_out_data;
                            else req0_out_data <= mem_out_data;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; drivers push expected completions, a negedge monitor
// checks grants, strobes, valid timing and read data against a cycle-level timing model.
module tb_mem_arbiter;
    localparam int L = 1;

    typedef struct {
        logic        wr;
        logic [31:0] data;
    } exp_t;

    logic        clock = 0;
    logic        reset = 1;
    logic        rd [2];
    logic        wr [2];
    logic [19:0] addr [2];
    logic [31:0] wdat [2];
    logic        req0_ready, req1_ready, req0_valid, req1_valid;
    logic [31:0] req0_out_data, req1_out_data;
    logic        mem_read, mem_write;
    logic [19:0] mem_address;
    logic [31:0] mem_in_data, mem_out_data;
    logic        report = 0;

    logic        r3 = 0;
    logic        zb = 0;
    logic [19:0] a3 = 0, za = 0;
    logic [31:0] zd = 0, md3;
    logic        rdy3_0, rdy3, vld3_0, vld3, mr3, mw3;
    logic [31:0] od3_0, od3, mi3;
    logic [19:0] ma3;
    int          run3 = 0;

    logic [31:0] ram [1024];
    logic [31:0] refm [1024];
    int          run = 0;
    exp_t        eq0[$], eq1[$];
    logic [31:0] held [2];
    int          checks = 0, errors = 0, cyc = 0;

    logic        busy, idle_exp, last, cur_p, cur_w, w, e_rd, e_wr, e_vld;
    logic [19:0] cur_addr;
    logic [31:0] cur_data;
    logic [1:0]  act, rdy_v, vld_v;
    int          t0;

    mem_arbiter #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .MEM_LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .req0_read(rd[0]), .req0_write(wr[0]), .req0_address(addr[0]), .req0_in_data(wdat[0]),
        .req0_ready(req0_ready), .req0_valid(req0_valid), .req0_out_data(req0_out_data),
        .req1_read(rd[1]), .req1_write(wr[1]), .req1_address(addr[1]), .req1_in_data(wdat[1]),
        .req1_ready(req1_ready), .req1_valid(req1_valid), .req1_out_data(req1_out_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_in_data(mem_in_data), .mem_out_data(mem_out_data), .report(report)
    );

    mem_arbiter #(.CORE(1), .DATA_WIDTH(32), .ADDRESS_BITS(20), .MEM_LATENCY(3)) u3 (
        .clock(clock), .reset(reset),
        .req0_read(zb), .req0_write(zb), .req0_address(za), .req0_in_data(zd),
        .req0_ready(rdy3_0), .req0_valid(vld3_0), .req0_out_data(od3_0),
        .req1_read(r3), .req1_write(zb), .req1_address(a3), .req1_in_data(zd),
        .req1_ready(rdy3), .req1_valid(vld3), .req1_out_data(od3),
        .mem_read(mr3), .mem_write(mw3), .mem_address(ma3),
        .mem_in_data(mi3), .mem_out_data(md3), .report(report)
    );

    always #5 clock = ~clock;

    // Memory models: data is only presented in the last cycle of the latency window.
    always @(posedge clock) begin
        if (mem_write) ram[mem_address[9:0]] <= mem_in_data;
        run  <= mem_read ? run + 1 : 0;
        run3 <= mr3 ? run3 + 1 : 0;
    end

    always @(negedge clock) begin
        mem_out_data <= (mem_read && run == L - 1) ? ram[mem_address[9:0]] : 32'hBAD0BAD0;
        md3 <= (mr3 && run3 == 2 && ma3 == 20'h00055) ? 32'h12345678 : 32'hBAD0BAD0;
    end

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h1357;
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, a, e, cyc);
        end
    endtask

    task automatic issue(input int p, input logic r, input logic wv, input logic [19:0] a,
                         input logic [31:0] d, input logic withdraw);
        exp_t e;
        bit   ok;
        rd[p] = r; wr[p] = wv; addr[p] = a; wdat[p] = d;
        e.wr = wv;
        e.data = wv ? 32'h0 : refm[a[9:0]];
        if (wv) refm[a[9:0]] = d;
        if (p == 0) eq0.push_back(e); else eq1.push_back(e);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if ((p == 0 ? req0_ready : req1_ready) === 1'b1) begin ok = 1; break; end
        end
        check($sformatf("p%0d_ready_timeout", p), 32'(ok), 1);
        @(posedge clock); #1;
        if (withdraw) begin rd[p] = 0; wr[p] = 0; end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ((p == 0 ? req0_valid : req1_valid) === 1'b1) begin ok = 1; break; end
        end
        check($sformatf("p%0d_valid_timeout", p), 32'(ok), 1);
        @(posedge clock); #1;
        rd[p] = 0; wr[p] = 0;
    endtask

    task automatic run_port(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int g  = $urandom_range(0, 2);
            int op = $urandom_range(0, 3);
            repeat (g) begin @(posedge clock); #1; end
            issue(p, op != 2, op >= 2, 20'((p + 1) * 256 + $urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0);
        end
    endtask

    // Monitor: model says who must be granted when idle, then when strobes and valid must appear.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            busy = 0; idle_exp = 1; last = 1; held[0] = 0; held[1] = 0;
            eq0.delete(); eq1.delete();
        end else begin
            cyc++;
            act   = {rd[1] | wr[1], rd[0] | wr[0]};
            rdy_v = {req1_ready, req0_ready};
            vld_v = {req1_valid, req0_valid};
            if (idle_exp && act != 0) begin
                w = (act == 2'b11) ? !last : act[1];
                check("grant", 32'(rdy_v), w ? 32'd2 : 32'd1);
                idle_exp = 0; busy = 1; cur_p = w; cur_w = wr[w];
                cur_addr = addr[w]; cur_data = wdat[w]; t0 = cyc; last = w;
            end else begin
                check("no_grant", 32'(rdy_v), 0);
            end
            e_rd  = busy && !cur_w && cyc > t0 && cyc <= t0 + L;
            e_wr  = busy && cur_w && cyc == t0 + 1;
            e_vld = busy && cyc == t0 + (cur_w ? 2 : L + 1);
            check("mem_read", 32'(mem_read), 32'(e_rd));
            check("mem_write", 32'(mem_write), 32'(e_wr));
            check("mem_address", 32'(mem_address), (e_rd || e_wr) ? 32'(cur_addr) : 0);
            if (!e_rd) check("mem_in_data", mem_in_data, e_wr ? cur_data : 0);
            check("valid", 32'(vld_v), e_vld ? (cur_p ? 32'd2 : 32'd1) : 0);
            for (int p = 0; p < 2; p++) begin
                if (vld_v[p]) begin
                    if ((p == 0 ? eq0.size() : eq1.size()) == 0) begin
                        check($sformatf("p%0d_unexpected_valid", p), 1, 0);
                    end else begin
                        exp_t x;
                        x = (p == 0) ? eq0.pop_front() : eq1.pop_front();
                        if (!x.wr) held[p] = x.data;
                    end
                end
                check($sformatf("p%0d_out_data", p), p == 0 ? req0_out_data : req1_out_data, held[p]);
            end
            if (e_vld) begin busy = 0; idle_exp = 1; end
        end
    end

    initial begin
        int c, v, n;
        logic [31:0] d;
        for (int i = 0; i < 1024; i++) begin ram[i] = init_val(i); refm[i] = init_val(i); end
        ram[16] = 32'hDEADBEEF; refm[16] = 32'hDEADBEEF;
        for (int p = 0; p < 2; p++) begin rd[p] = 0; wr[p] = 0; addr[p] = 0; wdat[p] = 0; end
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_ready", 32'({req1_ready, req0_ready}), 0);
        check("rst_valid", 32'({req1_valid, req0_valid}), 0);
        check("rst_strobes", 32'({mem_read, mem_write}), 0);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_in_data", mem_in_data, 0);
        check("rst_out0", req0_out_data, 0);
        check("rst_out1", req1_out_data, 0);
        @(posedge clock); #1;
        fork
            issue(0, 1, 0, 20'h00010, 0, 0);
            issue(1, 1, 0, 20'h00021, 0, 0);
        join
        check("single_read_data", req0_out_data, 32'hDEADBEEF);
        fork
            repeat (3) issue(0, 1, 0, 20'h00011, 0, 0);
            repeat (3) issue(1, 1, 0, 20'h00021, 0, 0);
        join
        issue(1, 0, 1, 20'h00020, 32'hCAFEF00D, 0);
        issue(1, 1, 0, 20'h00020, 0, 0);
        check("write_then_read", req1_out_data, 32'hCAFEF00D);
        issue(0, 1, 1, 20'h00040, 32'h11223344, 0);
        rd[1] = 1; addr[1] = 20'h00030;
        for (int i = 0; i < 10 && req1_ready !== 1'b1; i++) @(negedge clock);
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1 reset = 0; rd[1] = 0;
        @(negedge clock);
        check("abort_strobes", 32'({mem_read, mem_write}), 0);
        check("abort_valid1", 32'(req1_valid), 0);
        check("abort_out1", req1_out_data, 0);
        @(posedge clock); #1;
        fork
            issue(0, 1, 0, 20'h00010, 0, 0);
            issue(1, 1, 0, 20'h00020, 0, 0);
        join
        check("post_reset_read", req1_out_data, 32'hCAFEF00D);
        fork
            run_port(0, 40);
            run_port(1, 40);
        join
        @(posedge clock); #1;
        r3 = 1; a3 = 20'h00055;
        c = -100; v = 0; n = 0; d = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rdy3) c = i;
            if (mr3) n++;
            if (vld3) begin v = i; d = od3; break; end
        end
        @(posedge clock); #1 r3 = 0;
        check("l3_mem_read_cycles", 32'(n), 3);
        check("l3_valid_latency", 32'(v - c), 4);
        check("l3_data", d, 32'h12345678);
        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
